// File: rtl/dma_bus_arb_pkg.sv
// Shared state encodings and default sizing for the DMA bus arbiter.
package dma_bus_arb_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_IDW      = 2;
  localparam int DEF_MAX_HOLD = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GRANT   = 3'd2,
    GAP     = 3'd3,
    RELEASE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/dma_arb_rr_picker.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module dma_arb_rr_picker #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  win,
  output logic            valid
);

  int best;

  // Smallest forward distance from ptr wins; distance is (j - ptr) mod NREQ.
  always_comb begin
    best  = NREQ;
    win   = '0;
    valid = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (req[j] && (((j - int'(ptr) + NREQ) % NREQ) < best)) begin
        best  = (j - int'(ptr) + NREQ) % NREQ;
        win   = IDW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the 8088 local bus between the CPU (hold/hlda) and NREQ DMA masters.
// Optional tenure limit enabled by DMA_BUS_ARB_TIMEOUT_EN.
module dma_bus_arbiter
  import dma_bus_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int IDW      = DEF_IDW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  owner,
  output logic            hold,
  input  logic            hlda,
  output logic            aen,
  output logic            busy,
  output logic            err
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  if (NREQ < 2 || NREQ > 8 || (1 << IDW) < NREQ || MAX_HOLD < 1) begin : g_bad_params
    $error("dma_bus_arbiter: illegal NREQ/IDW/MAX_HOLD combination");
  end

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic           win_valid;
  logic           owner_req;
  logic           others;
  logic           preempt;

  dma_arb_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
    .req   (req),
    .ptr   (ptr),
    .win   (win),
    .valid (win_valid)
  );

  // gnt is one-hot on the owner while in GRANT, so it doubles as the owner mask.
  assign owner_req = |(req & gnt);
  assign others    = |(req & ~gnt);

`ifdef DMA_BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(MAX_HOLD + 1);
  logic [TW-1:0] tenure;

  // tenure holds the 1-based cycle number of the current GRANT tenure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          tenure <= TW'(1);
    else if (state != GRANT)          tenure <= TW'(1);
    else if (tenure != TW'(MAX_HOLD)) tenure <= tenure + 1'b1;
  end

  assign preempt = (tenure == TW'(MAX_HOLD)) && others;
`else
  assign preempt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hold  <= 1'b0;
      gnt   <= '0;
      aen   <= 1'b0;
      owner <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
      ptr   <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= REQ;
            hold  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (hlda) begin
            if (win_valid) begin
              state <= GRANT;
              gnt   <= ONE << win;
              aen   <= 1'b1;
              owner <= win;
              ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
            end else begin
              state <= RELEASE;
              hold  <= 1'b0;
            end
          end
        end
        GRANT: begin
          if (!hlda) begin
            state <= RELEASE;
            gnt   <= '0;
            aen   <= 1'b0;
            hold  <= 1'b0;
            err   <= 1'b1;
          end else if (!owner_req || preempt) begin
            gnt <= '0;
            aen <= 1'b0;
            if (others) begin
              state <= GAP;
            end else begin
              state <= RELEASE;
              hold  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (!hlda) begin
            state <= RELEASE;
            hold  <= 1'b0;
            err   <= 1'b1;
          end else if (win_valid) begin
            state <= GRANT;
            gnt   <= ONE << win;
            aen   <= 1'b1;
            owner <= win;
            ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          end else begin
            state <= RELEASE;
            hold  <= 1'b0;
          end
        end
        RELEASE: begin
          if (!hlda) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          hold  <= 1'b0;
          gnt   <= '0;
          aen   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
